daub4_lift_stream: RTL

//  Streaming one-level DAUB-4 lifting DWT with ready/valid handshakes and CHANNELS interleaved

---
 rtl/daub4_lift_stream.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/daub4_lift_stream.sv
// Streaming one-level DAUB-4 lifting DWT, interleaved channels.
// Input pair register, then d1, then s1/d2 with history, then scaled outputs.
module daub4_lift_stream #(
    parameter int DATA_W   = 32,
    parameter int FRAC     = 16,
    parameter int CHANNELS = 1,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter logic signed [DATA_W-1:0] C_ALPHA = 32'hFFFE4498,
    parameter logic signed [DATA_W-1:0] C_BETA  = 32'h00006EDA,
    parameter logic signed [DATA_W-1:0] C_GAMMA = 32'hFFFFEEDA,
    parameter logic signed [DATA_W-1:0] C_KL    = 32'h0001EE8E,
    parameter logic signed [DATA_W-1:0] C_KH    = 32'h00008484
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_l,
    output logic [DATA_W-1:0] out_h,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    output logic              frame_err
);
    localparam int NCH = 1 << CH_W;
    typedef logic signed [DATA_W-1:0] word_t;

    function automatic word_t mul(input word_t a, input word_t b);
        logic signed [2*DATA_W-1:0] p;
        p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return word_t'(p >>> FRAC);
    endfunction

    logic  ph  [NCH];
    logic  pf  [NCH];
    word_t pe  [NCH];
    word_t d1p [NCH];
    word_t s1p [NCH];

    logic  advance, acc, ch_ok, form, fclr;
    word_t fe, fo;

    logic            p_v, p_last, p_clr;
    logic [CH_W-1:0] p_ch;
    word_t           p_e, p_o;

    logic            s1_v, s1_last, s1_clr;
    logic [CH_W-1:0] s1_ch;
    word_t           s1_e, s1_d1;

    logic            s2_v, s2_last;
    logic [CH_W-1:0] s2_ch;
    word_t           s2_s1, s2_d2;

    word_t h_d1p, h_s1p, s1n, d2n;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;
    assign acc      = in_valid & advance;
    assign ch_ok    = int'(in_ch) < CHANNELS;

    // A first beat always behaves as even; its pair carries a history clear
    always_comb begin
        form = 1'b1;
        fe   = pe[in_ch];
        fo   = in_data;
        fclr = pf[in_ch];
        if (in_first || !ph[in_ch]) begin
            form = in_last;
            fe   = in_data;
            fo   = '0;
            fclr = in_first;
        end
    end

    always_comb begin
        h_d1p = s1_clr ? '0 : d1p[s1_ch];
        h_s1p = s1_clr ? '0 : s1p[s1_ch];
        s1n   = s1_e + mul(C_BETA, s1_d1) + mul(C_GAMMA, h_d1p);
        d2n   = s1_d1 + h_s1p;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                ph[i]  <= 1'b0;
                pf[i]  <= 1'b0;
                pe[i]  <= '0;
                d1p[i] <= '0;
                s1p[i] <= '0;
            end
            frame_err <= 1'b0;
            p_v <= 1'b0; p_last <= 1'b0; p_clr <= 1'b0;
            p_ch <= '0; p_e <= '0; p_o <= '0;
            s1_v <= 1'b0; s1_last <= 1'b0; s1_clr <= 1'b0;
            s1_ch <= '0; s1_e <= '0; s1_d1 <= '0;
            s2_v <= 1'b0; s2_last <= 1'b0;
            s2_ch <= '0; s2_s1 <= '0; s2_d2 <= '0;
            out_valid <= 1'b0;
            out_l     <= '0;
            out_h     <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (acc && ch_ok) begin
                if (in_first && ph[in_ch])
                    frame_err <= 1'b1;
                if (form) begin
                    ph[in_ch] <= 1'b0;
                end else begin
                    ph[in_ch] <= 1'b1;
                    pe[in_ch] <= in_data;
                    pf[in_ch] <= in_first;
                end
            end
            if (advance) begin
                p_v    <= acc & ch_ok & form;
                p_e    <= fe;
                p_o    <= fo;
                p_ch   <= in_ch;
                p_last <= in_last;
                p_clr  <= fclr;

                s1_v    <= p_v;
                s1_e    <= p_e;
                s1_d1   <= p_o + mul(C_ALPHA, p_e);
                s1_ch   <= p_ch;
                s1_last <= p_last;
                s1_clr  <= p_clr;

                s2_v    <= s1_v;
                s2_s1   <= s1n;
                s2_d2   <= d2n;
                s2_ch   <= s1_ch;
                s2_last <= s1_last;
                if (s1_v) begin
                    d1p[s1_ch] <= s1_d1;
                    s1p[s1_ch] <= s1n;
                end

                out_valid <= s2_v;
                out_l     <= mul(C_KL, s2_s1);
                out_h     <= mul(C_KH, s2_d2);
                out_ch    <= s2_ch;
                out_last  <= s2_last;
            end
        end
    end
endmodule
